// File: rtl/text_scroll_buffer.sv
// Marquee buffer: captures controller characters into a linear store and replays them
// cyclically, one per scroll tick. Optional `SCROLL_BLANK_EN inserts a space after the last character.
module text_scroll_buffer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int BASE_DIV = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        iData,
  input  logic              iWRen,
  input  logic [1:0]        iRate,
  input  logic              iCLEAN,
  input  logic              iFINISH,
  output logic [7:0]        oChar,
  output logic              oCharValid,
  output logic [ADDR_W:0]   oCount,
  output logic [1:0]        oRate,
  output logic              oOVF,
  output logic              oBusy
);

  localparam int CNT_W = $clog2(4 * BASE_DIV);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {EMPTY, RUN, PAUSE} state_t;

  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic                iWRen_q;
  logic                wr_pulse;
  logic                wr_acc;
  logic                tick;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     rd_next;
  logic [CNT_W-1:0]    tick_cnt;
`ifdef SCROLL_BLANK_EN
  logic                blank_pend;
`endif

  // Terminal count of the tick counter for a running rate; 2'b10 never reaches RUN.
  function automatic logic [CNT_W-1:0] period_last(input logic [1:0] rate);
    case (rate)
      2'b00:   return CNT_W'(4 * BASE_DIV - 1);
      2'b01:   return CNT_W'(2 * BASE_DIV - 1);
      default: return CNT_W'(BASE_DIV - 1);
    endcase
  endfunction

  assign wr_pulse = iWRen & ~iWRen_q;
  assign wr_acc   = wr_pulse & ~iCLEAN & (oCount != FULL);
  assign tick     = (state == RUN) && (tick_cnt == period_last(oRate));
  assign rd_next  = {1'b0, rd_ptr} + (ADDR_W+1)'(1);
  assign oBusy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[oCount[ADDR_W-1:0]] <= iData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      iWRen_q    <= 1'b0;
      oChar      <= 8'h00;
      oCharValid <= 1'b0;
      oCount     <= '0;
      oRate      <= 2'b00;
      oOVF       <= 1'b0;
      rd_ptr     <= '0;
      tick_cnt   <= '0;
`ifdef SCROLL_BLANK_EN
      blank_pend <= 1'b0;
`endif
    end else begin
      iWRen_q    <= iWRen;
      oCharValid <= 1'b0;
      if (iCLEAN) begin
        state    <= EMPTY;
        oCount   <= '0;
        rd_ptr   <= '0;
        tick_cnt <= '0;
        oOVF     <= 1'b0;
`ifdef SCROLL_BLANK_EN
        blank_pend <= 1'b0;
`endif
      end else begin
        if (wr_pulse) begin
          if (oCount == FULL) oOVF <= 1'b1;
          else                oCount <= oCount + (ADDR_W+1)'(1);
        end
        if (iFINISH) begin
          // A commit restarts the period; the newly committed rate decides the state.
          oRate    <= iRate;
          tick_cnt <= '0;
          case (state)
            EMPTY:   if (wr_pulse) state <= (iRate == 2'b10) ? PAUSE : RUN;
            RUN:     if (iRate == 2'b10) state <= PAUSE;
            PAUSE:   if (iRate != 2'b10) state <= RUN;
            default: state <= EMPTY;
          endcase
        end else begin
          case (state)
            EMPTY: begin
              tick_cnt <= '0;
              if (wr_pulse) state <= (oRate == 2'b10) ? PAUSE : RUN;
            end
            RUN: begin
              if (tick) begin
                tick_cnt   <= '0;
                oCharValid <= 1'b1;
`ifdef SCROLL_BLANK_EN
                if (blank_pend) begin
                  oChar      <= 8'h20;
                  blank_pend <= 1'b0;
                end else begin
                  oChar <= mem[rd_ptr];
                  if (rd_next == oCount) begin
                    rd_ptr     <= '0;
                    blank_pend <= 1'b1;
                  end else begin
                    rd_ptr <= rd_next[ADDR_W-1:0];
                  end
                end
`else
                oChar  <= mem[rd_ptr];
                rd_ptr <= (rd_next == oCount) ? '0 : rd_next[ADDR_W-1:0];
`endif
              end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
              end
            end
            PAUSE:   tick_cnt <= '0;
            default: state <= EMPTY;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_text_scroll_buffer.sv
// Directed bench for text_scroll_buffer with BASE_DIV=4; expectations follow SCROLL_BLANK_EN.
module tb_text_scroll_buffer;

  localparam int BD = 4;
`ifdef SCROLL_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] iData;
  logic       iWRen;
  logic [1:0] iRate;
  logic       iCLEAN;
  logic       iFINISH;
  logic [7:0] oChar;
  logic       oCharValid;
  logic [4:0] oCount;
  logic [1:0] oRate;
  logic       oOVF;
  logic       oBusy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  text_scroll_buffer #(.DEPTH(16), .ADDR_W(4), .BASE_DIV(BD)) dut (
    .clk(clk), .reset(reset), .iData(iData), .iWRen(iWRen), .iRate(iRate),
    .iCLEAN(iCLEAN), .iFINISH(iFINISH), .oChar(oChar), .oCharValid(oCharValid),
    .oCount(oCount), .oRate(oRate), .oOVF(oOVF), .oBusy(oBusy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_char(input logic [7:0] c);
    iData = c;
    iWRen = 1'b1;
    step();
    iWRen = 1'b0;
    step();
  endtask

  task automatic commit(input logic [1:0] r);
    iRate   = r;
    iFINISH = 1'b1;
    step();
    iFINISH = 1'b0;
  endtask

  // Steps until oCharValid is seen; n is the number of cycles waited.
  task automatic emit_check(input string tag, input int exp_n, input logic [7:0] exp_c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!oCharValid && n < 200);
    chk({tag, "_seen"}, 32'(oCharValid), 32'd1);
    chk({tag, "_gap"}, 32'(n), 32'(exp_n));
    chk({tag, "_char"}, 32'(oChar), 32'(exp_c));
  endtask

  task automatic silence(input string tag, input int cycles);
    int v;
    v = 0;
    repeat (cycles) begin
      step();
      if (oCharValid) v++;
    end
    chk(tag, 32'(v), 32'd0);
  endtask

  // Expected k-th character of the "HI" marquee.
  function automatic logic [7:0] hi_char(input int k);
    if (BLANK) return (k % 3 == 0) ? 8'h48 : (k % 3 == 1) ? 8'h49 : 8'h20;
    return (k % 2 == 0) ? 8'h48 : 8'h49;
  endfunction

  initial begin
    reset = 1'b1; iData = 8'h00; iWRen = 1'b0; iRate = 2'b00; iCLEAN = 1'b0; iFINISH = 1'b0;
    repeat (3) step();
    chk("rst_char", 32'(oChar), 32'h00);
    chk("rst_valid", 32'(oCharValid), 32'd0);
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_rate", 32'(oRate), 32'd0);
    chk("rst_ovf", 32'(oOVF), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    reset = 1'b0;
    step();

    // Two characters at rate 00: period 16, first emission 16 cycles after the first write.
    write_char(8'h48);
    write_char(8'h49);
    chk("hi_count", 32'(oCount), 32'd2);
    chk("hi_busy", 32'(oBusy), 32'd1);
    emit_check("hi0", 13, hi_char(0));
    for (int k = 1; k < 4; k++) emit_check($sformatf("hi%0d", k), 16, hi_char(k));

    // Commit rate 11 right after an emission, then change iRate without committing.
    commit(2'b11);
    chk("r11_rate", 32'(oRate), 32'd3);
    emit_check("r11_a", 4, hi_char(4));
    iRate = 2'b00;
    emit_check("r11_b", 4, hi_char(5));
    emit_check("r11_nocommit", 4, hi_char(6));

    // Pause, then resume at rate 01 from the held pointer.
    commit(2'b10);
    chk("pause_busy", 32'(oBusy), 32'd0);
    chk("pause_rate", 32'(oRate), 32'd2);
    silence("pause_silent", 40);
    commit(2'b01);
    chk("resume_busy", 32'(oBusy), 32'd1);
    emit_check("r01_a", 8, hi_char(7));
    emit_check("r01_b", 8, hi_char(8));

    // Clear landing on the same edge as a write pulse and a tick.
    repeat (7) step();
    iCLEAN = 1'b1; iWRen = 1'b1; iData = 8'h58;
    step();
    iCLEAN = 1'b0; iWRen = 1'b0;
    chk("clr_valid", 32'(oCharValid), 32'd0);
    chk("clr_count", 32'(oCount), 32'd0);
    chk("clr_busy", 32'(oBusy), 32'd0);
    chk("clr_rate", 32'(oRate), 32'd1);
    silence("clr_silent", 20);

    // Held write strobe yields a single write.
    iData = 8'h5A; iWRen = 1'b1;
    repeat (10) step();
    iWRen = 1'b0;
    step();
    chk("hold_count", 32'(oCount), 32'd1);
    chk("hold_busy", 32'(oBusy), 32'd1);
    iCLEAN = 1'b1;
    step();
    iCLEAN = 1'b0;
    chk("hold_clr_count", 32'(oCount), 32'd0);

    // Fill while paused: 17 writes, last one dropped.
    commit(2'b10);
    for (int i = 0; i < 17; i++) write_char(8'(8'h41 + i));
    chk("full_count", 32'(oCount), 32'd16);
    chk("full_ovf", 32'(oOVF), 32'd1);
    chk("full_busy", 32'(oBusy), 32'd0);
    commit(2'b11);
    for (int i = 0; i < 16; i++) emit_check($sformatf("full%0d", i), 4, 8'(8'h41 + i));
    emit_check("full_wrap", 4, BLANK ? 8'h20 : 8'h41);

    // Clear with a coincident write pulse wipes count and overflow, keeps rate.
    iCLEAN = 1'b1; iWRen = 1'b1; iData = 8'h58;
    step();
    iCLEAN = 1'b0; iWRen = 1'b0;
    chk("clr2_count", 32'(oCount), 32'd0);
    chk("clr2_ovf", 32'(oOVF), 32'd0);
    chk("clr2_busy", 32'(oBusy), 32'd0);
    chk("clr2_rate", 32'(oRate), 32'd3);
    silence("clr2_silent", 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
